// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Shares the single write port of a gray-pointer FIFO between NREQ burst
// requesters with round-robin arbitration. The write-side pointer is kept in
// binary (for the RAM address) and gray (for the read clock domain). The full
// flag is derived from the gray read pointer, which arrives already
// synchronized to clk. A level-sensitive flush drops the grant, clears the
// pointers and holds flushDone high until flush is released.
//
// Parameters
//   ADDRWIDTH  FIFO depth is 2**ADDRWIDTH; pointers are ADDRWIDTH+1 bits (>= 2)
//   NREQ       number of requesters (>= 2)
//   DATAWIDTH  beat width
//
// Ports
//   clk            clock
//   hardReset_n    synchronous active-low reset
//   flush          flush request (level); overrides every other activity
//   flushDone      high for every cycle spent in FLUSH
//   req            per-requester request, held for the whole burst
//   reqLast        marks the final beat of a burst
//   reqData        beat data, requester i owns [i*DATAWIDTH +: DATAWIDTH]
//   grant          registered one-hot burst grant
//   reqAck         combinational per-requester beat accept
//   wrEn           registered RAM write enable
//   wrAddr         registered RAM write address
//   wrData         registered RAM write data
//   wrPtrGray      registered gray write pointer for the read domain
//   rdPtrGraySync  gray read pointer, already synchronized to clk
//   fifoFull       combinational full flag
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int ADDRWIDTH = 6,
  parameter int NREQ      = 4,
  parameter int DATAWIDTH = 32
) (
  input  logic                      clk,
  input  logic                      hardReset_n,
  input  logic                      flush,
  output logic                      flushDone,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           reqLast,
  input  logic [NREQ*DATAWIDTH-1:0] reqData,
  output logic [NREQ-1:0]           grant,
  output logic [NREQ-1:0]           reqAck,
  output logic                      wrEn,
  output logic [ADDRWIDTH-1:0]      wrAddr,
  output logic [DATAWIDTH-1:0]      wrData,
  output logic [ADDRWIDTH:0]        wrPtrGray,
  input  logic [ADDRWIDTH:0]        rdPtrGraySync,
  output logic                      fifoFull
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PTRW = ADDRWIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t               state;
  state_t               stateNext;
  logic [NREQ-1:0]      grantNext;
  logic [IDXW-1:0]      lastGrant;
  logic [IDXW-1:0]      lastGrantNext;
  logic [PTRW-1:0]      wrPtrBin;
  logic [PTRW-1:0]      ptrInc;
  logic [PTRW-1:0]      ptrIncGray;
  logic [NREQ-1:0]      pickOneHot;
  logic                 pickFound;
  logic [IDXW-1:0]      grantIdx;
  logic [DATAWIDTH-1:0] selData;
  logic                 selLast;
  logic                 beatOk;
  logic                 accept;

  // Full when the write pointer is exactly one lap ahead of the read pointer;
  // in gray code that means the top two bits differ and the rest match.
  assign fifoFull = (wrPtrGray ==
                     {~rdPtrGraySync[ADDRWIDTH:ADDRWIDTH-1],
                      rdPtrGraySync[ADDRWIDTH-2:0]});

  // flush gates the accept so a beat offered in the flush cycle is refused.
  assign beatOk    = (state == BURST) && !fifoFull && !flush;
  assign reqAck    = grant & req & {NREQ{beatOk}};
  assign accept    = |reqAck;
  assign flushDone = (state == FLUSH);

  assign ptrInc     = wrPtrBin + PTRW'(1);
  assign ptrIncGray = ptrInc ^ (ptrInc >> 1);

  // Round-robin pick: first search the indices above lastGrant, then wrap
  // around to the indices at or below it, so the last winner is tried last.
  always_comb begin
    pickOneHot = '0;
    pickFound  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!pickFound && req[i] && (i > int'(lastGrant))) begin
        pickOneHot[i] = 1'b1;
        pickFound     = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!pickFound && req[i] && (i <= int'(lastGrant))) begin
        pickOneHot[i] = 1'b1;
        pickFound     = 1'b1;
      end
    end
  end

  // Decode the one-hot grant into an index plus the granted beat's data and
  // last flag. With no grant everything stays at zero.
  always_comb begin
    grantIdx = '0;
    selData  = '0;
    selLast  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        grantIdx = IDXW'(i);
        selData  = reqData[i*DATAWIDTH +: DATAWIDTH];
        selLast  = reqLast[i];
      end
    end
  end

  // Next-state logic. flush wins in every state; the grant is dropped on the
  // same edge that enters FLUSH.
  always_comb begin
    stateNext     = state;
    grantNext     = grant;
    lastGrantNext = lastGrant;
    case (state)
      IDLE: begin
        if (flush) begin
          stateNext = FLUSH;
          grantNext = '0;
        end else if (pickFound) begin
          stateNext = BURST;
          grantNext = pickOneHot;
        end
      end
      BURST: begin
        if (flush) begin
          stateNext = FLUSH;
          grantNext = '0;
        end else if (accept && selLast) begin
          stateNext     = IDLE;
          grantNext     = '0;
          lastGrantNext = grantIdx;
        end
      end
      FLUSH: begin
        grantNext = '0;
        if (!flush) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
        grantNext = '0;
      end
    endcase
  end

  // State, grant and write datapath registers. The RAM write lands one cycle
  // after the accept, using the pointer value from before the increment.
  always_ff @(posedge clk) begin
    if (!hardReset_n) begin
      state     <= IDLE;
      grant     <= '0;
      lastGrant <= IDXW'(NREQ - 1);
      wrEn      <= 1'b0;
      wrAddr    <= '0;
      wrData    <= '0;
      wrPtrBin  <= '0;
      wrPtrGray <= '0;
    end else begin
      state     <= stateNext;
      grant     <= grantNext;
      lastGrant <= lastGrantNext;
      wrEn      <= accept;
      if (accept) begin
        wrAddr    <= wrPtrBin[ADDRWIDTH-1:0];
        wrData    <= selData;
        wrPtrBin  <= ptrInc;
        wrPtrGray <= ptrIncGray;
      end else if (flush) begin
        wrPtrBin  <= '0;
        wrPtrGray <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Directed bench for fifo_wr_arbiter with default parameters (ADDRWIDTH=6,
// NREQ=4, DATAWIDTH=32). Inputs change 1 time unit after the rising edge and
// outputs are compared after they settle, away from the edge.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  logic         clk = 1'b0;
  logic         hardReset_n;
  logic         flush;
  logic         flushDone;
  logic [3:0]   req;
  logic [3:0]   reqLast;
  logic [127:0] reqData;
  logic [3:0]   grant;
  logic [3:0]   reqAck;
  logic         wrEn;
  logic [5:0]   wrAddr;
  logic [31:0]  wrData;
  logic [6:0]   wrPtrGray;
  logic [6:0]   rdPtrGraySync;
  logic         fifoFull;

  int errors = 0;
  int checks = 0;

  fifo_wr_arbiter #(
    .ADDRWIDTH(6),
    .NREQ(4),
    .DATAWIDTH(32)
  ) dut (
    .clk(clk),
    .hardReset_n(hardReset_n),
    .flush(flush),
    .flushDone(flushDone),
    .req(req),
    .reqLast(reqLast),
    .reqData(reqData),
    .grant(grant),
    .reqAck(reqAck),
    .wrEn(wrEn),
    .wrAddr(wrAddr),
    .wrData(wrData),
    .wrPtrGray(wrPtrGray),
    .rdPtrGraySync(rdPtrGraySync),
    .fifoFull(fifoFull)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dataWord(input int idx, input int beat);
    return {8'hDA, 8'(idx), 16'(beat)};
  endfunction

  function automatic logic [6:0] gray7(input int n);
    logic [6:0] b;
    b = 7'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadData(input int beat);
    for (int i = 0; i < 4; i++) reqData[i*32 +: 32] = dataWord(i, beat);
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l);
    req     = r;
    reqLast = l;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulseReset();
    hardReset_n = 1'b0;
    tick();
    hardReset_n = 1'b1;
  endtask

  initial begin
    hardReset_n   = 1'b0;
    flush         = 1'b0;
    req           = '0;
    reqLast       = '0;
    rdPtrGraySync = '0;
    loadData(0);
    tick();
    tick();

    $display("[TB] reset values");
    checkOutput("rst_grant",     64'(grant),     64'd0);
    checkOutput("rst_wrEn",      64'(wrEn),      64'd0);
    checkOutput("rst_wrAddr",    64'(wrAddr),    64'd0);
    checkOutput("rst_wrData",    64'(wrData),    64'd0);
    checkOutput("rst_wrPtrGray", 64'(wrPtrGray), 64'd0);
    checkOutput("rst_flushDone", 64'(flushDone), 64'd0);
    checkOutput("rst_fifoFull",  64'(fifoFull),  64'd0);
    checkOutput("rst_reqAck",    64'(reqAck),    64'd0);

    $display("[TB] 3-beat burst from requester 0");
    hardReset_n = 1'b1;
    loadData(1);
    applyStimulus(4'b0001, 4'b0000);
    tick();
    checkOutput("b3_grant", 64'(grant), 64'b0001);
    checkOutput("b3_ack",   64'(reqAck), 64'b0001);
    tick();
    checkOutput("b3_wrEn1",  64'(wrEn),      64'd1);
    checkOutput("b3_addr1",  64'(wrAddr),    64'd0);
    checkOutput("b3_data1",  64'(wrData),    64'(dataWord(0, 1)));
    checkOutput("b3_gray1",  64'(wrPtrGray), 64'b0000001);
    loadData(2);
    tick();
    checkOutput("b3_wrEn2",  64'(wrEn),      64'd1);
    checkOutput("b3_addr2",  64'(wrAddr),    64'd1);
    checkOutput("b3_data2",  64'(wrData),    64'(dataWord(0, 2)));
    checkOutput("b3_gray2",  64'(wrPtrGray), 64'b0000011);
    loadData(3);
    applyStimulus(4'b0001, 4'b0001);
    tick();
    checkOutput("b3_wrEn3",  64'(wrEn),      64'd1);
    checkOutput("b3_addr3",  64'(wrAddr),    64'd2);
    checkOutput("b3_data3",  64'(wrData),    64'(dataWord(0, 3)));
    checkOutput("b3_gray3",  64'(wrPtrGray), 64'b0000010);
    checkOutput("b3_grant0", 64'(grant),     64'd0);
    applyStimulus(4'b0000, 4'b0000);
    tick();
    checkOutput("b3_wrEnOff", 64'(wrEn), 64'd0);

    $display("[TB] round robin with all requesters active");
    pulseReset();
    loadData(7);
    applyStimulus(4'b1111, 4'b1111);
    begin
      logic [3:0] order [5];
      int         idx   [5];
      order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      idx   = '{0, 1, 2, 3, 0};
      for (int k = 0; k < 5; k++) begin
        tick();
        checkOutput($sformatf("rr_grant_%0d", k), 64'(grant), 64'(order[k]));
        tick();
        checkOutput($sformatf("rr_idle_%0d", k), 64'(grant), 64'd0);
        checkOutput($sformatf("rr_wrEn_%0d", k), 64'(wrEn), 64'd1);
        checkOutput($sformatf("rr_data_%0d", k), 64'(wrData),
                    64'(dataWord(idx[k], 7)));
      end
    end
    applyStimulus(4'b0000, 4'b0000);

    $display("[TB] fill to full with requester 2");
    pulseReset();
    rdPtrGraySync = '0;
    applyStimulus(4'b0100, 4'b0000);
    tick();
    checkOutput("full_grant", 64'(grant), 64'b0100);
    for (int b = 0; b < 64; b++) begin
      loadData(b);
      tick();
      checkOutput($sformatf("full_addr_%0d", b), 64'(wrAddr), 64'(b));
      checkOutput($sformatf("full_wrEn_%0d", b), 64'(wrEn), 64'd1);
    end
    checkOutput("full_gray",    64'(wrPtrGray), 64'b1100000);
    checkOutput("full_flag",    64'(fifoFull),  64'd1);
    checkOutput("full_noAck",   64'(reqAck),    64'd0);
    checkOutput("full_lastDat", 64'(wrData),    64'(dataWord(2, 63)));
    tick();
    checkOutput("full_stallWrEn",  64'(wrEn),  64'd0);
    checkOutput("full_stallGrant", 64'(grant), 64'b0100);
    checkOutput("full_stillFull",  64'(fifoFull), 64'd1);
    rdPtrGraySync = 7'b0000001;
    loadData(64);
    applyStimulus(4'b0100, 4'b0100);
    checkOutput("full_release", 64'(fifoFull), 64'd0);
    checkOutput("full_ackBack", 64'(reqAck),   64'b0100);
    tick();
    checkOutput("full_wrapWrEn", 64'(wrEn),   64'd1);
    checkOutput("full_wrapAddr", 64'(wrAddr), 64'd0);
    checkOutput("full_wrapData", 64'(wrData), 64'(dataWord(2, 64)));
    checkOutput("full_endGrant", 64'(grant),  64'd0);
    applyStimulus(4'b0000, 4'b0000);

    $display("[TB] 130 single-beat writes with tracking read pointer");
    pulseReset();
    rdPtrGraySync = '0;
    applyStimulus(4'b0010, 4'b0010);
    for (int n = 0; n < 130; n++) begin
      tick();
      checkOutput($sformatf("wrap_grant_%0d", n), 64'(grant), 64'b0010);
      tick();
      checkOutput($sformatf("wrap_addr_%0d", n), 64'(wrAddr), 64'(n % 64));
      checkOutput($sformatf("wrap_gray_%0d", n), 64'(wrPtrGray), 64'(gray7(n + 1)));
      if (n == 63) checkOutput("wrap_gray64", 64'(wrPtrGray), 64'b1100000);
      rdPtrGraySync = gray7(n + 1);
    end
    applyStimulus(4'b0000, 4'b0000);

    $display("[TB] flush in the middle of a burst");
    pulseReset();
    rdPtrGraySync = '0;
    applyStimulus(4'b0001, 4'b0000);
    tick();
    checkOutput("fl_grant", 64'(grant), 64'b0001);
    tick();
    tick();
    checkOutput("fl_preGray", 64'(wrPtrGray), 64'b0000011);
    flush = 1'b1;
    #1;
    checkOutput("fl_ackBlocked", 64'(reqAck), 64'd0);
    tick();
    checkOutput("fl_grant0",  64'(grant),     64'd0);
    checkOutput("fl_wrEn0",   64'(wrEn),      64'd0);
    checkOutput("fl_gray0",   64'(wrPtrGray), 64'd0);
    checkOutput("fl_done1",   64'(flushDone), 64'd1);
    tick();
    checkOutput("fl_done2",   64'(flushDone), 64'd1);
    tick();
    checkOutput("fl_done3",   64'(flushDone), 64'd1);
    checkOutput("fl_grantF",  64'(grant),     64'd0);
    flush = 1'b0;
    #1;
    tick();
    checkOutput("fl_idleDone",  64'(flushDone), 64'd0);
    checkOutput("fl_idleGrant", 64'(grant),     64'd0);
    tick();
    checkOutput("fl_regrant", 64'(grant), 64'b0001);
    tick();
    checkOutput("fl_wrEn",  64'(wrEn),      64'd1);
    checkOutput("fl_addr",  64'(wrAddr),    64'd0);
    checkOutput("fl_gray",  64'(wrPtrGray), 64'b0000001);

    $display("[TB] reset in the middle of a burst");
    hardReset_n = 1'b0;
    tick();
    checkOutput("mr_grant", 64'(grant),     64'd0);
    checkOutput("mr_wrEn",  64'(wrEn),      64'd0);
    checkOutput("mr_addr",  64'(wrAddr),    64'd0);
    checkOutput("mr_data",  64'(wrData),    64'd0);
    checkOutput("mr_gray",  64'(wrPtrGray), 64'd0);
    checkOutput("mr_done",  64'(flushDone), 64'd0);
    hardReset_n = 1'b1;
    applyStimulus(4'b0000, 4'b0000);
    tick();
    checkOutput("mr_quiet1", 64'(wrEn), 64'd0);
    tick();
    checkOutput("mr_quiet2", 64'(wrEn),  64'd0);
    checkOutput("mr_noGrnt", 64'(grant), 64'd0);
    loadData(9);
    applyStimulus(4'b1000, 4'b1000);
    tick();
    checkOutput("mr_grant3", 64'(grant), 64'b1000);
    tick();
    checkOutput("mr_wrEn3", 64'(wrEn),   64'd1);
    checkOutput("mr_addr3", 64'(wrAddr), 64'd0);
    checkOutput("mr_data3", 64'(wrData), 64'(dataWord(3, 9)));
    applyStimulus(4'b0000, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
